fpu_dispatch: RTL and testbench

Command-buffering front end that sits directly upstream of the `fpu` core. It accepts floating-point operation requests (op, A, B) through a valid/ready handshake into a small FIFO. It issues them to the FPU one at a time using the FPU's `start`/`done` protocol. Results are returned in issue order on a valid/ready output port, with a timeout watchdog so a hung FPU cannot stall the datapath.

---
 rtl/fpu_pkg.sv | 27 ++
 rtl/fpu_cmd_fifo.sv | 54 +++++
 rtl/fpu_dispatch.sv | 154 +++++++++++++++
 tb/tb_fpu_dispatch.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU command front end: opcodes, FSM encoding,
// command word layout and the quiet-NaN pattern used for timed-out results.
package fpu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [31:0] QNAN = 32'h7FC00000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/fpu_cmd_fifo.sv
// Synchronous command FIFO with pointer-plus-count occupancy tracking.
// Head entry is visible combinationally so the dispatcher can pop and latch in one cycle.
module fpu_cmd_fifo #(
  parameter int WIDTH = 66,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  // A push while full is dropped even if a pop happens in the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/fpu_dispatch.sv
// Buffers FPU requests, issues them one at a time with a start/done handshake,
// and returns results in order; a watchdog substitutes a NaN error result if done never rises.
module fpu_dispatch
  import fpu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        fpu_start,
  output logic [1:0]  fpu_op,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  input  logic [31:0] fpu_r,
  input  logic        fpu_done,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_r,
  output logic        out_err,
  output logic        busy
);

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        start_q, start_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] r_q, r_d;
  logic        err_q, err_d;
  logic        valid_q, valid_d;
  logic        done_q, done_prev_q;
  logic        done_rise;

  cmd_t        wcmd;
  cmd_t        head;
  logic        fifo_full, fifo_empty, push, pop;

  assign wcmd     = {in_op, in_a, in_b};
  assign in_ready = ~fifo_full;
  assign push     = in_valid & in_ready;

  fpu_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (wcmd),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Edge is taken between two registered samples, so a done level already
  // present when WAIT is entered never looks like a completion.
  assign done_rise = done_q & ~done_prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      tmo_q       <= '0;
      start_q     <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      r_q         <= '0;
      err_q       <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      done_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      start_q     <= start_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      r_q         <= r_d;
      err_q       <= err_d;
      valid_q     <= valid_d;
      done_q      <= fpu_done;
      done_prev_q <= done_q;
    end
  end

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    start_d = 1'b0;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    err_d   = err_q;
    valid_d = valid_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          op_d    = head.op;
          a_d     = head.a;
          b_d     = head.b;
          tmo_d   = '0;
          start_d = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        tmo_d = tmo_q + 8'd1;
        if (done_rise) begin
          r_d     = fpu_r;
          err_d   = 1'b0;
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end else if (tmo_q == TMO_LIMIT) begin
          r_d     = QNAN;
          err_d   = 1'b1;
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign fpu_start = start_q;
  assign fpu_op    = op_q;
  assign fpu_a     = a_q;
  assign fpu_b     = b_q;
  assign out_valid = valid_q;
  assign out_r     = r_q;
  assign out_err   = err_q;
  assign busy      = (state_q != ST_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_fpu_dispatch.sv
// Directed bench for fpu_dispatch: behavioural FPU model, result scoreboard,
// latency/back-pressure/stuck-done/timeout/reset scenarios.
module tb_fpu_dispatch;
  import fpu_pkg::*;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a, in_b;
  logic        fpu_start;
  logic [1:0]  fpu_op;
  logic [31:0] fpu_a, fpu_b;
  logic [31:0] fpu_r;
  logic        fpu_done;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_r;
  logic        out_err;
  logic        busy;

  fpu_dispatch #(.DEPTH(4), .TIMEOUT(20)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_r(fpu_r), .fpu_done(fpu_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_err(out_err),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-precision <-> real conversion for normal numbers and zero.
  function automatic real sp2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) d = {f[31], 63'd0};
    else d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  function automatic logic [31:0] fp_calc(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    real x, y, z;
    x = sp2r(a);
    y = sp2r(b);
    case (op)
      OP_ADD:  z = x + y;
      OP_SUB:  z = x - y;
      OP_MUL:  z = x * y;
      default: z = x / y;
    endcase
    return r2sp(z);
  endfunction

  // FPU model: done rises lat cycles after the start pulse; lat==0 never completes.
  int          lat;
  int          mdl_cnt;
  logic        mdl_done;
  logic [31:0] mdl_r;
  logic        model_en;
  logic        man_done;
  logic [31:0] man_r;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mdl_done <= 1'b0;
      mdl_cnt  <= 0;
      mdl_r    <= '0;
    end else if (fpu_start) begin
      mdl_done <= 1'b0;
      mdl_cnt  <= lat;
      mdl_r    <= fp_calc(fpu_op, fpu_a, fpu_b);
    end else if (mdl_cnt != 0) begin
      mdl_cnt <= mdl_cnt - 1;
      if (mdl_cnt == 1) mdl_done <= 1'b1;
    end
  end

  assign fpu_done = model_en ? mdl_done : man_done;
  assign fpu_r    = model_en ? mdl_r : man_r;

  int start_cnt = 0;
  always @(posedge clk) if (fpu_start) start_cnt <= start_cnt + 1;

  typedef struct {
    logic [31:0] r;
    logic        err;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp_r, input logic exp_err);
    int w = 0;
    in_valid = 1'b1;
    in_op = op;
    in_a = a;
    in_b = b;
    while (!in_ready && w < 100) begin
      tick();
      w++;
    end
    check("push_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    sb.push_back('{exp_r, exp_err});
  endtask

  task automatic push_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    push(op, a, b, fp_calc(op, a, b), 1'b0);
  endtask

  task automatic drain(input int n);
    int   got = 0;
    exp_t e;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 300 && got < n; cyc++) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          $display("result out_r=%h out_err=%b (exp %h/%b)", out_r, out_err, e.r, e.err);
          check("out_r", out_r, e.r);
          check("out_err", 32'(out_err), 32'(e.err));
        end
        got++;
      end
      tick();
    end
    out_ready = 1'b0;
    check("drain_count", 32'(got), 32'(n));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_fpu_start"}, 32'(fpu_start), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_err"}, 32'(out_err), 32'd0);
    check({tag, "_out_r"}, out_r, 32'd0);
    check({tag, "_fpu_a"}, fpu_a, 32'd0);
    check({tag, "_fpu_b"}, fpu_b, 32'd0);
    check({tag, "_fpu_op"}, 32'(fpu_op), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int s0;
    reset = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
    out_ready = 1'b0; model_en = 1'b1; lat = 10; man_done = 1'b0; man_r = '0;
    tick(); tick();
    check_reset_outputs("por");
    reset = 1'b1;
    tick();

    // Single add with 10-cycle FPU latency.
    s0 = start_cnt;
    push_op(OP_ADD, 32'h40000000, 32'h3F800000);
    check("add_busy", 32'(busy), 32'd1);
    tick();
    check("add_start_hi", 32'(fpu_start), 32'd1);
    check("add_fpu_a", fpu_a, 32'h40000000);
    check("add_fpu_b", fpu_b, 32'h3F800000);
    check("add_fpu_op", 32'(fpu_op), 32'(OP_ADD));
    tick();
    check("add_start_lo", 32'(fpu_start), 32'd0);
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    check("add_latency", 32'(n), 32'd12);
    check("add_result", out_r, 32'h40400000);
    check("add_err", 32'(out_err), 32'd0);
    drain(1);
    check("add_starts", 32'(start_cnt - s0), 32'd1);
    check("add_idle", 32'(busy), 32'd0);

    // Back-pressure: five requests, consumer stalled.
    lat = 3;
    push_op(OP_ADD, 32'h3FC00000, 32'h40100000);
    push_op(OP_SUB, 32'h40A00000, 32'h3F800000);
    push_op(OP_MUL, 32'h40400000, 32'h3F000000);
    push_op(OP_DIV, 32'h41100000, 32'h40800000);
    push_op(OP_ADD, 32'hC0000000, 32'h3F000000);
    check("bp_full", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_op = OP_MUL; in_a = 32'h3F800000; in_b = 32'h3F800000;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_still_full", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    check("bp_busy", 32'(busy), 32'd1);
    drain(5);
    for (int i = 0; i < 10; i++) tick();
    check("bp_no_extra", 32'(out_valid), 32'd0);
    check("bp_idle", 32'(busy), 32'd0);
    check("bp_ready", 32'(in_ready), 32'd1);

    // Stuck done: level already high at issue must not complete.
    model_en = 1'b0; man_done = 1'b1; man_r = 32'h12345678;
    tick();
    push(OP_ADD, 32'h3F800000, 32'h3F800000, 32'h12345678, 1'b0);
    for (int i = 0; i < 8; i++) tick();
    check("stuck_no_done", 32'(out_valid), 32'd0);
    man_done = 1'b0;
    tick(); tick();
    check("stuck_low", 32'(out_valid), 32'd0);
    man_done = 1'b1;
    tick();
    check("stuck_edge_pending", 32'(out_valid), 32'd0);
    tick();
    check("stuck_edge_valid", 32'(out_valid), 32'd1);
    drain(1);
    man_done = 1'b0; model_en = 1'b1;
    tick();

    // Timeout, then a normal command behind it.
    lat = 0;
    s0 = start_cnt;
    push(OP_ADD, 32'h3F800000, 32'h40000000, QNAN, 1'b1);
    push_op(OP_MUL, 32'h40000000, 32'h40400000);
    tick();
    lat = 4;
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    check("tmo_latency", 32'(n), 32'd21);
    check("tmo_r", out_r, QNAN);
    check("tmo_err", 32'(out_err), 32'd1);
    drain(2);
    check("tmo_starts", 32'(start_cnt - s0), 32'd2);

    // Reset while waiting, two commands still queued.
    lat = 0;
    push_op(OP_ADD, 32'h3F800000, 32'h3F800000);
    push_op(OP_SUB, 32'h40000000, 32'h3F800000);
    push_op(OP_MUL, 32'h40000000, 32'h40000000);
    tick(); tick(); tick();
    check("rst_pre_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check_reset_outputs("midwait");
    sb.delete();
    tick();
    reset = 1'b1;
    s0 = start_cnt;
    for (int i = 0; i < 10; i++) tick();
    check("rst_no_start", 32'(start_cnt - s0), 32'd0);
    check("rst_idle", 32'(busy), 32'd0);
    check("rst_no_valid", 32'(out_valid), 32'd0);
    lat = 2;
    push_op(OP_SUB, 32'h40800000, 32'h40000000);
    drain(1);
    check("rst_new_start", 32'(start_cnt - s0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
